shared_timer_scheduler: RTL and testbench
=========================================

Name: shared_timer_scheduler

Overview:
- Shares one down-counter among NUM_REQ requesters; each requester needs a delay of its own length, such as debounce, key-repeat or display blink.
- A round-robin arbiter grants the counter to one requester at a time.
- The count is loaded from that requester's count input, and the block returns a one-cycle done pulse on that requester's lane.
- Sits between the keypad/display control FSMs and the clock domain, and replaces one fixed-period timer instance per requester.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..8.
- COUNT_WIDTH, 24, width of each requested cycle count; 24 bits covers 335 ms at a 20 ns clock.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  clock enable; when low, all state is held.
- sync_resetn  in  1  synchronous, active-low reset; only acts when enable=1.
- req  in  NUM_REQ  level request per requester; held high until done or until the requester abandons the request.
- req_count  in  NUM_REQ*COUNT_WIDTH  per-requester delay in clock cycles; lane i is bits [i*COUNT_WIDTH +: COUNT_WIDTH].
- grant  out  NUM_REQ  one-hot; the requester currently owning the counter; all-zero when idle.
- done  out  NUM_REQ  one-hot, one-cycle pulse when the granted delay has expired.
- busy  out  1  high while the counter is owned by a requester.

Behaviour:
- States: IDLE, COUNTING, EXPIRED.
- resetn low, or sync_resetn low with enable=1:
  - state=IDLE, count=0, last_idx=NUM_REQ-1.
  - grant=0, done=0, busy=0.
- All state updates are qualified by enable. With enable=0, state, count and last_idx are held and done is forced to 0.
- IDLE:
  - With any req bit set, pick the first set bit scanning from (last_idx+1) mod NUM_REQ upward, wrapping around.
  - Latch cur_idx and count = max(req_count[cur_idx],1) - 1, then go to COUNTING.
  - The requested count is sampled only at this edge; later changes to req_count are ignored for that grant.
- COUNTING:
  - grant[cur_idx]=1 and busy=1.
  - If count==0, go to EXPIRED; otherwise decrement count.
  - Cancel: if req[cur_idx]=0 at any COUNTING edge, go to IDLE, set last_idx=cur_idx, and emit no done pulse. Cancel takes priority over expiry in the same cycle.
- EXPIRED:
  - done[cur_idx]=enable. grant and busy stay high for this cycle.
  - Next edge: set last_idx=cur_idx and go to IDLE.
- Latency:
  - Request seen at IDLE edge k, so grant rises after edge k.
  - done is high in the cycle after edge k+N, where N=max(req_count,1) counted in enabled cycles.
  - Next grant follows one IDLE cycle later, giving a 1-cycle turnaround.
- Fairness: a requester that keeps req high after its done is served again only after every other pending requester has been served once.
- Count arithmetic is unsigned; there is no wrap, because count only decrements toward 0.
- All outputs are decoded from registered state and cur_idx; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package:
  - state encodings IDLE=2'b00, COUNTING=2'b01, EXPIRED=2'b10;
  - a helper function for lane slicing of req_count.
- One sub-module, rr_pick: a combinational rotating-priority picker.
  - Inputs: req[NUM_REQ] and last_idx.
  - Outputs: valid and idx[$clog2(NUM_REQ)-1:0].
  - Reused by future bus/display arbiters.
- Counter and FSM stay in shared_timer_scheduler.

Test Plan:
- Single request: after reset, req=4'b0001 with req_count[0]=5 → grant=0001 one cycle later; done[0] pulses exactly once, 5 cycles after grant rises; back to IDLE with busy=0.
- Simultaneous requests: after reset, req=0101 with both counts=3 → lane 0 is served first, then lane 2 with a 1-cycle IDLE gap. Keeping req[0] high afterwards → order 0,2,0,2.
- Zero count: req_count[1]=0, req=0010 → done[1] in the cycle after the first COUNTING edge, behaving identically to count=1.
- Cancel: lane 3 has count=10 and req[3] drops after 4 cycles → no done[3]; IDLE on the next edge; a pending req[0] is granted next.
- Enable freeze: with count=6, hold enable=0 for 7 cycles mid-count → count and grant frozen, done=0; done arrives 7 cycles late with no double pulse.
- Resets mid-operation:
  - sync_resetn=0 with enable=1 during COUNTING → IDLE and grant=0 at the next edge, no done, and lane 0 regains top priority.
  - The same sequence with async resetn → outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/shared_timer_scheduler_pkg.sv
// Shared definitions for the timer scheduler: FSM state encoding and a
// helper that extracts one lane from a packed per-requester count bus.
package shared_timer_scheduler_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned MAX_CW  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        COUNTING = 2'b01,
        EXPIRED  = 2'b10
    } state_t;

    // Bus is zero-extended by the caller to the maximum supported size.
    function automatic logic [MAX_CW-1:0] lane_slice(
        input logic [MAX_REQ*MAX_CW-1:0] bus,
        input int unsigned               idx,
        input int unsigned               width
    );
        logic [MAX_REQ*MAX_CW-1:0] shifted;
        logic [MAX_REQ*MAX_CW-1:0] mask;
        shifted = bus >> (idx * width);
        mask    = ~({(MAX_REQ*MAX_CW){1'b1}} << width);
        return MAX_CW'(shifted & mask);
    endfunction

endpackage

// File: rtl/shared_timer_scheduler_rr_pick.sv
// Combinational rotating-priority picker: first set req bit scanning upward
// from (last_idx+1) mod NUM_REQ, wrapping around.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        logic        found;
        int unsigned pos;
        valid = |req;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos = (32'(last_idx) + k) % NUM_REQ;
            if (!found && req[IDX_W'(pos)]) begin
                idx   = IDX_W'(pos);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_timer_scheduler.sv
// One shared down-counter granted round-robin to NUM_REQ requesters; each grant
// loads that requester's delay and ends with a one-cycle done pulse on its lane.
module shared_timer_scheduler
    import shared_timer_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned COUNT_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           enable,
    input  logic                           sync_resetn,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_count,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t                   state;
    logic [COUNT_WIDTH-1:0]   count;
    logic [IDX_W-1:0]         cur_idx;
    logic [IDX_W-1:0]         last_idx;

    logic                     pick_valid;
    logic [IDX_W-1:0]         pick_idx;
    logic [MAX_REQ*MAX_CW-1:0] bus_ext;
    logic [COUNT_WIDTH-1:0]   cnt_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (req),
        .last_idx (last_idx),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    always_comb begin
        bus_ext = '0;
        bus_ext[NUM_REQ*COUNT_WIDTH-1:0] = req_count;
        cnt_req = COUNT_WIDTH'(lane_slice(bus_ext, 32'(pick_idx), COUNT_WIDTH));
    end

    // Outputs are registered alongside the state so no input reaches them combinationally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            count    <= '0;
            cur_idx  <= '0;
            last_idx <= IDX_W'(NUM_REQ - 1);
            grant    <= '0;
            done     <= '0;
            busy     <= 1'b0;
        end else if (!enable) begin
            done <= '0;
        end else if (!sync_resetn) begin
            state    <= IDLE;
            count    <= '0;
            cur_idx  <= '0;
            last_idx <= IDX_W'(NUM_REQ - 1);
            grant    <= '0;
            done     <= '0;
            busy     <= 1'b0;
        end else begin
            done <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= COUNTING;
                        cur_idx <= pick_idx;
                        count   <= (cnt_req == '0) ? '0 : cnt_req - COUNT_WIDTH'(1);
                        grant   <= NUM_REQ'(1) << pick_idx;
                        busy    <= 1'b1;
                    end
                end
                COUNTING: begin
                    if (!req[cur_idx]) begin
                        state    <= IDLE;
                        last_idx <= cur_idx;
                        grant    <= '0;
                        busy     <= 1'b0;
                    end else if (count == '0) begin
                        state <= EXPIRED;
                        done  <= NUM_REQ'(1) << cur_idx;
                    end else begin
                        count <= count - COUNT_WIDTH'(1);
                    end
                end
                EXPIRED: begin
                    state    <= IDLE;
                    last_idx <= cur_idx;
                    grant    <= '0;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_timer_scheduler.sv
// Scoreboard bench for shared_timer_scheduler: expected done pulses (lane and
// cycle) are queued when requests are driven and matched as pulses appear.
module tb_shared_timer_scheduler;

    localparam int NR = 4;
    localparam int CW = 24;

    logic             clk;
    logic             resetn;
    logic             enable;
    logic             sync_resetn;
    logic [NR-1:0]    req;
    logic [NR*CW-1:0] req_count;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    done;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int lane;
        int at;
    } exp_t;
    exp_t exp_q[$];

    shared_timer_scheduler #(
        .NUM_REQ     (NR),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .sync_resetn (sync_resetn),
        .req         (req),
        .req_count   (req_count),
        .grant       (grant),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (resetn && done !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=%b at cycle %0d, expected none", done, cyc);
            end else begin
                exp_t e;
                logic [NR-1:0] want;
                e = exp_q.pop_front();
                want = NR'(1) << e.lane;
                if (done !== want) begin
                    errors++;
                    $display("FAIL done_lane: got %b, expected %b", done, want);
                end
                checks++;
                if (cyc !== e.at) begin
                    errors++;
                    $display("FAIL done_cycle: lane %0d at cycle %0d, expected %0d", e.lane, cyc, e.at);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d, expected finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic set_count(input int lane, input int v);
        req_count[lane*CW +: CW] = CW'(v);
    endtask

    task automatic push_exp(input int lane, input int at);
        exp_t e;
        e.lane = lane;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string name, input logic [NR-1:0] g, input logic b);
        checks++;
        if (grant !== g || busy !== b) begin
            errors++;
            $display("FAIL %s: got grant=%b busy=%b, expected grant=%b busy=%b", name, grant, busy, g, b);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d missing done pulses, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        resetn      = 1'b0;
        enable      = 1'b1;
        sync_resetn = 1'b1;
        req         = '0;
        req_count   = '0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (grant !== '0 || done !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got grant=%b done=%b busy=%b, expected all 0", grant, done, busy);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int c0;
        test_reset();
        c0 = cyc;
        set_count(0, 5);
        push_exp(0, c0 + 6);
        req = 4'b0001;
        wait_until(c0 + 1);
        check_out("single_grant", 4'b0001, 1'b1);
        wait_until(c0 + 6);
        req = '0;
        wait_until(c0 + 7);
        check_out("single_idle", 4'b0000, 1'b0);
        wait_until(c0 + 10);
        check_drained("single_drained");
    endtask

    task automatic test_back_to_back;
        int c0;
        test_reset();
        c0 = cyc;
        set_count(0, 3);
        set_count(2, 3);
        push_exp(0, c0 + 4);
        push_exp(2, c0 + 9);
        push_exp(0, c0 + 14);
        push_exp(2, c0 + 19);
        req = 4'b0101;
        wait_until(c0 + 1);
        check_out("b2b_first", 4'b0001, 1'b1);
        wait_until(c0 + 5);
        check_out("b2b_gap", 4'b0000, 1'b0);
        wait_until(c0 + 6);
        check_out("b2b_second", 4'b0100, 1'b1);
        wait_until(c0 + 11);
        check_out("b2b_third", 4'b0001, 1'b1);
        wait_until(c0 + 16);
        check_out("b2b_fourth", 4'b0100, 1'b1);
        wait_until(c0 + 19);
        req = '0;
        wait_until(c0 + 23);
        check_out("b2b_idle", 4'b0000, 1'b0);
        check_drained("b2b_drained");
    endtask

    task automatic test_zero_count;
        int c0;
        test_reset();
        c0 = cyc;
        set_count(1, 0);
        push_exp(1, c0 + 2);
        req = 4'b0010;
        wait_until(c0 + 1);
        check_out("zero_grant", 4'b0010, 1'b1);
        wait_until(c0 + 2);
        req = '0;
        wait_until(c0 + 3);
        check_out("zero_idle", 4'b0000, 1'b0);
        wait_until(c0 + 6);
        check_drained("zero_drained");
    endtask

    task automatic test_cancel;
        int c0;
        test_reset();
        c0 = cyc;
        set_count(3, 10);
        set_count(0, 2);
        req = 4'b1000;
        wait_until(c0 + 1);
        check_out("cancel_grant3", 4'b1000, 1'b1);
        wait_until(c0 + 5);
        push_exp(0, c0 + 9);
        req = 4'b0001;
        wait_until(c0 + 6);
        check_out("cancel_idle", 4'b0000, 1'b0);
        wait_until(c0 + 7);
        check_out("cancel_grant0", 4'b0001, 1'b1);
        wait_until(c0 + 9);
        req = '0;
        wait_until(c0 + 16);
        check_drained("cancel_drained");
    endtask

    task automatic test_enable_freeze;
        int c0;
        test_reset();
        c0 = cyc;
        set_count(0, 6);
        push_exp(0, c0 + 14);
        req = 4'b0001;
        wait_until(c0 + 3);
        enable = 1'b0;
        wait_until(c0 + 7);
        check_out("freeze_hold", 4'b0001, 1'b1);
        checks++;
        if (done !== '0) begin
            errors++;
            $display("FAIL freeze_done: got %b, expected 0000", done);
        end
        wait_until(c0 + 10);
        enable = 1'b1;
        wait_until(c0 + 14);
        req = '0;
        wait_until(c0 + 18);
        check_out("freeze_idle", 4'b0000, 1'b0);
        check_drained("freeze_drained");
    endtask

    task automatic test_sync_reset;
        int c0;
        test_reset();
        c0 = cyc;
        set_count(1, 8);
        set_count(0, 2);
        set_count(2, 2);
        req = 4'b0010;
        wait_until(c0 + 1);
        check_out("sreset_grant1", 4'b0010, 1'b1);
        wait_until(c0 + 3);
        req = 4'b0111;
        sync_resetn = 1'b0;
        wait_until(c0 + 4);
        check_out("sreset_idle", 4'b0000, 1'b0);
        sync_resetn = 1'b1;
        push_exp(0, c0 + 7);
        wait_until(c0 + 5);
        check_out("sreset_prio0", 4'b0001, 1'b1);
        wait_until(c0 + 7);
        req = '0;
        wait_until(c0 + 11);
        check_drained("sreset_drained");
    endtask

    task automatic test_async_reset;
        int c0;
        test_reset();
        c0 = cyc;
        set_count(1, 8);
        set_count(0, 2);
        set_count(2, 2);
        req = 4'b0010;
        wait_until(c0 + 3);
        req = 4'b0111;
        #2;
        resetn = 1'b0;
        #1;
        check_out("areset_immediate", 4'b0000, 1'b0);
        wait_until(c0 + 4);
        resetn = 1'b1;
        push_exp(0, c0 + 7);
        wait_until(c0 + 5);
        check_out("areset_prio0", 4'b0001, 1'b1);
        wait_until(c0 + 7);
        req = '0;
        wait_until(c0 + 11);
        check_drained("areset_drained");
    endtask

    initial begin
        resetn      = 1'b0;
        enable      = 1'b1;
        sync_resetn = 1'b1;
        req         = '0;
        req_count   = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_count();
        test_cancel();
        test_enable_freeze();
        test_sync_reset();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
